// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register-file reads, forwards from EX/MEM/WB,
// stalls on load-use, and holds resolved operands in an ID/EX register.
module operand_fetch_stage #(
  parameter int RWIDTH  = 6,
  parameter int DWIDTH  = 32,
  parameter int CWIDTH  = 16,
  parameter int SCWIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RWIDTH-1:0]  in_ra1,
  input  logic [RWIDTH-1:0]  in_ra2,
  input  logic [RWIDTH-1:0]  in_wa,
  input  logic [CWIDTH-1:0]  in_ctrl,
  input  logic               in_uses_ra2,
  output logic [RWIDTH-1:0]  rf_ra1,
  output logic [RWIDTH-1:0]  rf_ra2,
  input  logic [DWIDTH-1:0]  rf_rd1,
  input  logic [DWIDTH-1:0]  rf_rd2,
  input  logic               ex_we,
  input  logic               ex_is_load,
  input  logic [RWIDTH-1:0]  ex_wa,
  input  logic [DWIDTH-1:0]  ex_wd,
  input  logic               mem_we,
  input  logic [RWIDTH-1:0]  mem_wa,
  input  logic [DWIDTH-1:0]  mem_wd,
  input  logic               wb_we,
  input  logic [RWIDTH-1:0]  wb_wa,
  input  logic [DWIDTH-1:0]  wb_wd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DWIDTH-1:0]  out_op1,
  output logic [DWIDTH-1:0]  out_op2,
  output logic [RWIDTH-1:0]  out_wa,
  output logic [CWIDTH-1:0]  out_ctrl,
  output logic [SCWIDTH-1:0] stall_cnt
);

  logic               valid_q, valid_d;
  logic [DWIDTH-1:0]  op1_q, op1_d, op2_q, op2_d;
  logic [RWIDTH-1:0]  wa_q, wa_d;
  logic [CWIDTH-1:0]  ctrl_q, ctrl_d;
  logic [SCWIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic              hazard;
  logic              fire;
  logic [DWIDTH-1:0] sel_op1, sel_op2;

  // EX results of loads are not ready yet, so EX forwarding skips loads.
  function automatic logic [DWIDTH-1:0] resolve(
    input logic [RWIDTH-1:0] s,
    input logic [DWIDTH-1:0] rf_rd,
    input logic              ex_fwd_en,
    input logic [RWIDTH-1:0] ex_a,
    input logic [DWIDTH-1:0] ex_d,
    input logic              mem_en,
    input logic [RWIDTH-1:0] mem_a,
    input logic [DWIDTH-1:0] mem_d,
    input logic              wb_en,
    input logic [RWIDTH-1:0] wb_a,
    input logic [DWIDTH-1:0] wb_d
  );
    logic [DWIDTH-1:0] r;
    if (s == '0)                        r = '0;
    else if (ex_fwd_en && ex_a == s)    r = ex_d;
    else if (mem_en && mem_a == s)      r = mem_d;
    else if (wb_en && wb_a == s)        r = wb_d;
    else                                r = rf_rd;
    return r;
  endfunction

  assign rf_ra1 = in_ra1;
  assign rf_ra2 = in_ra2;

  always_comb begin
    sel_op1 = resolve(in_ra1, rf_rd1, ex_we && !ex_is_load, ex_wa, ex_wd,
                      mem_we, mem_wa, mem_wd, wb_we, wb_wa, wb_wd);
    sel_op2 = resolve(in_ra2, rf_rd2, ex_we && !ex_is_load, ex_wa, ex_wd,
                      mem_we, mem_wa, mem_wd, wb_we, wb_wa, wb_wd);
  end

  assign hazard = in_valid && ex_we && ex_is_load && (ex_wa != '0) &&
                  ((ex_wa == in_ra1) || (in_uses_ra2 && (ex_wa == in_ra2)));
  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
  assign fire     = in_valid && in_ready;

  always_comb begin
    valid_d     = valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    wa_d        = wa_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (fire) begin
      valid_d = 1'b1;
      op1_d   = sel_op1;
      op2_d   = sel_op2;
      wa_d    = in_wa;
      ctrl_d  = in_ctrl;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    // Saturate rather than wrap so a long stall never reads as a short one.
    if (hazard && !flush && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      wa_q        <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      wa_q        <= wa_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_op1   = op1_q;
  assign out_op2   = op2_q;
  assign out_wa    = wa_q;
  assign out_ctrl  = ctrl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus a
// randomized run against a behavioural model of the stage.
module tb_operand_fetch_stage;
  localparam int RW = 6, DW = 32, CW = 16, SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid, in_uses_ra2, ex_we, ex_is_load, mem_we, wb_we, flush, out_ready;
  logic [RW-1:0] in_ra1, in_ra2, in_wa, ex_wa, mem_wa, wb_wa;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] rf_rd1, rf_rd2, ex_wd, mem_wd, wb_wd;
  logic          in_ready, out_valid;
  logic [RW-1:0] rf_ra1, rf_ra2, out_wa;
  logic [DW-1:0] out_op1, out_op2;
  logic [CW-1:0] out_ctrl;
  logic [SW-1:0] stall_cnt;

  int tests_run = 0;
  int failures  = 0;

  // Model state
  logic          m_valid;
  logic [DW-1:0] m_op1, m_op2;
  logic [RW-1:0] m_wa;
  logic [CW-1:0] m_ctrl;
  logic [SW-1:0] m_cnt;

  always #5 clk = ~clk;

  operand_fetch_stage #(.RWIDTH(RW), .DWIDTH(DW), .CWIDTH(CW), .SCWIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra1(in_ra1), .in_ra2(in_ra2), .in_wa(in_wa), .in_ctrl(in_ctrl),
    .in_uses_ra2(in_uses_ra2),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wa(ex_wa), .ex_wd(ex_wd),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_wa(out_wa), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  task automatic idle_inputs();
    in_valid = 0; in_uses_ra2 = 1; ex_we = 0; ex_is_load = 0; mem_we = 0; wb_we = 0;
    flush = 0; out_ready = 1;
    in_ra1 = 0; in_ra2 = 0; in_wa = 0; ex_wa = 0; mem_wa = 0; wb_wa = 0; in_ctrl = 0;
    rf_rd1 = 0; rf_rd2 = 0; ex_wd = 0; mem_wd = 0; wb_wd = 0;
  endtask

  // Newest writer wins; a load still in EX has no data to offer.
  function automatic logic [DW-1:0] model_operand(input logic [RW-1:0] s, input logic [DW-1:0] rf);
    logic          en [3];
    logic [RW-1:0] a  [3];
    logic [DW-1:0] d  [3];
    en[0] = ex_we && !ex_is_load; a[0] = ex_wa;  d[0] = ex_wd;
    en[1] = mem_we;               a[1] = mem_wa; d[1] = mem_wd;
    en[2] = wb_we;                a[2] = wb_wa;  d[2] = wb_wd;
    if (s == 0) return '0;
    for (int i = 0; i < 3; i++)
      if (en[i] && a[i] == s) return d[i];
    return rf;
  endfunction

  function automatic bit model_hazard();
    bit src_match;
    src_match = (ex_wa == in_ra1) || (in_uses_ra2 && ex_wa == in_ra2);
    return in_valid && ex_we && ex_is_load && ex_wa != 0 && src_match;
  endfunction

  function automatic bit model_ready();
    return (!m_valid || out_ready) && !model_hazard() && !flush;
  endfunction

  task automatic model_clock();
    bit hz, take;
    hz   = model_hazard();
    take = in_valid && model_ready();
    if (flush) m_valid = 0;
    else if (take) begin
      m_valid = 1; m_op1 = model_operand(in_ra1, rf_rd1); m_op2 = model_operand(in_ra2, rf_rd2);
      m_wa = in_wa; m_ctrl = in_ctrl;
    end else if (out_ready) m_valid = 0;
    if (hz && !flush && m_cnt != {SW{1'b1}}) m_cnt = m_cnt + 1;
  endtask

  task automatic apply_reset();
    rst_n = 0; #2; rst_n = 1;
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_wa = 0; m_ctrl = 0; m_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    in_valid = 1; in_ra1 = 1; in_ra2 = 2; rf_rd1 = 32'h55; rf_rd2 = 32'h66; in_ctrl = 16'h1234;
    ex_we = 1; ex_is_load = 1; ex_wa = 9; // unrelated load
    @(posedge clk); #1;
    ex_wa = 1; // now a load-use hazard to advance stall_cnt
    @(posedge clk); #3;
    rst_n = 0; #1;
    tests_run++;
    if (out_valid !== 0 || out_op1 !== 0 || out_op2 !== 0 || stall_cnt !== 0 || out_ctrl !== 0) begin
      failures++;
      $display("FAIL reset: valid=%0b op1=%h op2=%h cnt=%0d ctrl=%h, required all zero",
               out_valid, out_op1, out_op2, stall_cnt, out_ctrl);
    end
    $display("[TB] reset: valid=%0b op1=%h op2=%h cnt=%0d", out_valid, out_op1, out_op2, stall_cnt);
    idle_inputs();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_rf_read();
    idle_inputs();
    in_valid = 1; in_ra1 = 3; in_ra2 = 4; in_wa = 10; in_ctrl = 16'hBEEF;
    rf_rd1 = 32'h1111_1111; rf_rd2 = 32'h2222_2222;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1 || rf_ra1 !== 3 || rf_ra2 !== 4) begin
      failures++;
      $display("FAIL rf_read_ready: in_ready=%0b rf_ra1=%0d rf_ra2=%0d, required 1/3/4", in_ready, rf_ra1, rf_ra2);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1 || out_op1 !== 32'h1111_1111 || out_op2 !== 32'h2222_2222 ||
        out_wa !== 10 || out_ctrl !== 16'hBEEF) begin
      failures++;
      $display("FAIL rf_read: valid=%0b op1=%h op2=%h wa=%0d ctrl=%h, required 1 11111111 22222222 10 beef",
               out_valid, out_op1, out_op2, out_wa, out_ctrl);
    end
    $display("[TB] rf_read: op1=%h op2=%h", out_op1, out_op2);
    idle_inputs();
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 0) begin
      failures++;
      $display("FAIL drain: out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_forward_priority();
    logic [DW-1:0] exp_q[3];
    exp_q[0] = 32'hA; exp_q[1] = 32'hB; exp_q[2] = 32'hC;
    for (int step = 0; step < 3; step++) begin
      idle_inputs();
      in_valid = 1; in_ra1 = 5; in_ra2 = 6; rf_rd1 = 32'h5555; rf_rd2 = 32'h6666;
      ex_we = (step == 0); mem_we = (step <= 1); wb_we = 1;
      ex_wa = 5; mem_wa = 5; wb_wa = 5;
      ex_wd = 32'hA; mem_wd = 32'hB; wb_wd = 32'hC;
      @(posedge clk); #1;
      tests_run++;
      if (out_op1 !== exp_q[step] || out_op2 !== 32'h6666 || out_valid !== 1) begin
        failures++;
        $display("FAIL fwd_prio step%0d: op1=%h op2=%h valid=%0b, required %h 6666 1",
                 step, out_op1, out_op2, out_valid, exp_q[step]);
      end
      $display("[TB] fwd_prio step%0d: op1=%h", step, out_op1);
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    logic [SW-1:0] cnt0;
    cnt0 = stall_cnt === 0 ? 0 : stall_cnt; // reset state was checked earlier; expect 0
    idle_inputs();
    in_valid = 1; in_ra1 = 1; in_ra2 = 7; in_uses_ra2 = 1; in_wa = 3;
    rf_rd1 = 32'h0101; rf_rd2 = 32'h7777;
    ex_we = 1; ex_is_load = 1; ex_wa = 7;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 0) begin
      failures++;
      $display("FAIL load_use_ready: in_ready=%0b, required 0", in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (stall_cnt !== 1 || out_valid !== 0) begin
      failures++;
      $display("FAIL load_use_stall: cnt=%0d valid=%0b, required 1 0", stall_cnt, out_valid);
    end
    ex_we = 0; ex_is_load = 0; mem_we = 1; mem_wa = 7; mem_wd = 32'hDEAD;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1) begin
      failures++;
      $display("FAIL load_use_release: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1 || out_op2 !== 32'hDEAD || out_op1 !== 32'h0101 || stall_cnt !== 1) begin
      failures++;
      $display("FAIL load_use_fire: valid=%0b op1=%h op2=%h cnt=%0d, required 1 0101 dead 1",
               out_valid, out_op1, out_op2, stall_cnt);
    end
    $display("[TB] load_use: op2=%h cnt=%0d (start %0d)", out_op2, stall_cnt, cnt0);
    idle_inputs();
    in_valid = 1; in_ra1 = 1; in_ra2 = 7; in_uses_ra2 = 0; rf_rd1 = 32'h0101; rf_rd2 = 32'h7777;
    ex_we = 1; ex_is_load = 1; ex_wa = 7;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1) begin
      failures++;
      $display("FAIL no_ra2_ready: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (stall_cnt !== 1 || out_op2 !== 32'h7777 || out_valid !== 1) begin
      failures++;
      $display("FAIL no_ra2: cnt=%0d op2=%h valid=%0b, required 1 7777 1", stall_cnt, out_op2, out_valid);
    end
    $display("[TB] no_ra2: op2=%h cnt=%0d", out_op2, stall_cnt);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    idle_inputs();
    in_valid = 1; in_ra1 = 2; in_ra2 = 3; in_wa = 4; in_ctrl = 16'hAAAA;
    rf_rd1 = 32'hA1; rf_rd2 = 32'hA2;
    @(posedge clk); #1;
    in_ra1 = 8; in_ra2 = 9; in_wa = 11; in_ctrl = 16'hBBBB; rf_rd1 = 32'hB1; rf_rd2 = 32'hB2;
    mem_we = 1; mem_wa = 2; mem_wd = 32'hFACE; // would re-resolve op1 if it were not held
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 0) begin
        failures++;
        $display("FAIL bp_ready c%0d: in_ready=%0b, required 0", c, in_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1 || out_op1 !== 32'hA1 || out_op2 !== 32'hA2 || out_wa !== 4 || out_ctrl !== 16'hAAAA) begin
        failures++;
        $display("FAIL bp_hold c%0d: valid=%0b op1=%h op2=%h wa=%0d ctrl=%h, required 1 a1 a2 4 aaaa",
                 c, out_valid, out_op1, out_op2, out_wa, out_ctrl);
      end
      $display("[TB] bp_hold c%0d: op1=%h ctrl=%h", c, out_op1, out_ctrl);
    end
    out_ready = 1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1) begin
      failures++;
      $display("FAIL bp_release: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1 || out_op1 !== 32'hB1 || out_op2 !== 32'hB2 || out_ctrl !== 16'hBBBB) begin
      failures++;
      $display("FAIL bp_capture: valid=%0b op1=%h op2=%h ctrl=%h, required 1 b1 b2 bbbb",
               out_valid, out_op1, out_op2, out_ctrl);
    end
    $display("[TB] bp_capture: op1=%h ctrl=%h", out_op1, out_ctrl);
  endtask

  task automatic test_flush_zero();
    idle_inputs();
    in_valid = 1; flush = 1; in_ra1 = 12; in_ra2 = 13; rf_rd1 = 32'hC1; rf_rd2 = 32'hC2; in_ctrl = 16'hCCCC;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 0) begin
      failures++;
      $display("FAIL flush_ready: in_ready=%0b, required 0", in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 0 || out_op1 !== 32'hB1 || out_ctrl !== 16'hBBBB) begin
      failures++;
      $display("FAIL flush: valid=%0b op1=%h ctrl=%h, required 0 b1 bbbb", out_valid, out_op1, out_ctrl);
    end
    $display("[TB] flush: valid=%0b op1=%h", out_valid, out_op1);
    idle_inputs();
    in_valid = 1; in_ra1 = 0; in_ra2 = 0; rf_rd1 = 32'h1234_5678; rf_rd2 = 32'h8765_4321;
    wb_we = 1; wb_wa = 0; wb_wd = 32'hFFFF_FFFF; mem_we = 1; mem_wa = 0; mem_wd = 32'hEEEE_EEEE;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1 || out_op1 !== 0 || out_op2 !== 0) begin
      failures++;
      $display("FAIL zero_reg: valid=%0b op1=%h op2=%h, required 1 0 0", out_valid, out_op1, out_op2);
    end
    $display("[TB] zero_reg: op1=%h op2=%h", out_op1, out_op2);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit exp_rdy;
    int bad;
    idle_inputs();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_uses_ra2 = $urandom_range(0, 1);
      in_ra1 = $urandom_range(0, 7); in_ra2 = $urandom_range(0, 7); in_wa = $urandom_range(0, 63);
      in_ctrl = $urandom;
      rf_rd1 = $urandom; rf_rd2 = $urandom;
      ex_we = $urandom_range(0, 1); ex_is_load = $urandom_range(0, 1);
      ex_wa = $urandom_range(0, 7); ex_wd = $urandom;
      mem_we = $urandom_range(0, 1); mem_wa = $urandom_range(0, 7); mem_wd = $urandom;
      wb_we = $urandom_range(0, 1); wb_wa = $urandom_range(0, 7); wb_wd = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      exp_rdy = model_ready();
      @(negedge clk);
      tests_run++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rand_ready n%0d: in_ready=%0b, required %0b", n, in_ready, exp_rdy);
      end
      model_clock();
      @(posedge clk); #1;
      tests_run++;
      bad = (out_valid !== m_valid) || (stall_cnt !== m_cnt) ||
            (out_op1 !== m_op1) || (out_op2 !== m_op2) || (out_wa !== m_wa) || (out_ctrl !== m_ctrl);
      if (bad != 0) begin
        failures++;
        $display("FAIL rand_state n%0d: v=%0b op1=%h op2=%h wa=%0d ctrl=%h cnt=%0d, required v=%0b op1=%h op2=%h wa=%0d ctrl=%h cnt=%0d",
                 n, out_valid, out_op1, out_op2, out_wa, out_ctrl, stall_cnt,
                 m_valid, m_op1, m_op2, m_wa, m_ctrl, m_cnt);
      end
      if (n % 50 == 0)
        $display("[TB] rand n%0d: v=%0b op1=%h op2=%h cnt=%0d", n, out_valid, out_op1, out_op2, stall_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #2 rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_rf_read();
    test_forward_priority();
    test_load_use();
    test_backpressure();
    test_flush_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute stage that sits directly in front of the 32-bit register file and after it.
- Drives the register-file read addresses and takes the combinational read data back.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and stalls on load-use.
- Holds operands in an ID/EX pipeline register with a valid/ready handshake, flush, and a saturating stall counter.

Parameters:
- RWIDTH, 6, register address width (2**RWIDTH registers; register 0 reads as zero).
- DWIDTH, 32, data width.
- CWIDTH, 16, opaque control bundle width, passed through unchanged.
- SCWIDTH, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_ra1, in_ra2  in  RWIDTH  source register addresses.
- in_wa  in  RWIDTH  destination register address.
- in_ctrl  in  CWIDTH  control bundle.
- in_uses_ra2  in  1  instruction reads ra2; when 0, ra2 is excluded from hazard checks.
- rf_ra1, rf_ra2  out  RWIDTH  register-file read addresses, equal to in_ra1/in_ra2 combinationally.
- rf_rd1, rf_rd2  in  DWIDTH  register-file combinational read data.
- ex_we, ex_is_load  in  1  EX-stage write enable, and EX instruction is a load.
- ex_wa  in  RWIDTH  EX-stage destination.
- ex_wd  in  DWIDTH  EX-stage ALU result.
- mem_we  in  1  MEM-stage write enable.
- mem_wa  in  RWIDTH  MEM-stage destination.
- mem_wd  in  DWIDTH  MEM-stage result, including load data.
- wb_we  in  1  WB write enable; the same signal drives the register-file write port.
- wb_wa  in  RWIDTH  WB destination.
- wb_wd  in  DWIDTH  WB data.
- flush  in  1  kill the held instruction and reject new input.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the instruction this cycle.
- out_op1, out_op2  out  DWIDTH  resolved operands.
- out_wa  out  RWIDTH  registered destination.
- out_ctrl  out  CWIDTH  registered control bundle.
- stall_cnt  out  SCWIDTH  count of load-use stall cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_op1=0, out_op2=0, out_wa=0, out_ctrl=0, stall_cnt=0. Reset mid-stall drops the pending instruction.
- Operand select per source s (ra1, ra2), priority order:
  - s==0 gives 0.
  - else ex_we && !ex_is_load && ex_wa==s gives ex_wd.
  - else mem_we && mem_wa==s gives mem_wd.
  - else wb_we && wb_wa==s gives wb_wd. This bypass is required because the register file writes at the clock edge and a same-cycle read returns the old value.
  - else rf_rdN.
- Load-use hazard: in_valid && ex_we && ex_is_load && ex_wa!=0, and (ex_wa==in_ra1, or in_uses_ra2 && ex_wa==in_ra2).
- in_ready = (!out_valid || out_ready) && !hazard && !flush. in_ready is combinational.
- Fire = in_valid && in_ready. On fire, at the next edge:
  - out_valid<=1
  - out_op1/out_op2 <= selected operands
  - out_wa<=in_wa, out_ctrl<=in_ctrl
- No fire and out_ready: out_valid<=0. Data registers hold their values.
- No fire and !out_ready: all outputs hold. Operands were resolved at capture and do not re-resolve.
- flush has priority over everything: at the next edge out_valid<=0 and no capture occurs. Data registers hold their values.
- stall_cnt increments by 1 at each edge where hazard && !flush. It saturates at all-ones and never wraps.
- Latency: one cycle from fire to out_valid. Full throughput when out_ready=1 and there is no hazard.
- A write to register 0 from any stage is never forwarded.

Test Plan:
- Reset then idle: rst_n low mid-cycle → out_valid, out_op1, out_op2 and stall_cnt equal 0 immediately, without waiting for a clock edge.
- Register-file read: rf_rd1=32'h1111_1111, rf_rd2=32'h2222_2222, no forwarding → next cycle out_op1=32'h1111_1111, out_op2=32'h2222_2222, out_valid=1.
- Forward priority: ra1=5 with ex_wa=5 (ex_wd=32'hA), mem_wa=5 (32'hB) and wb_wa=5 (32'hC) all writing → out_op1=32'hA. Dropping ex_we → 32'hB. Dropping mem_we as well → 32'hC.
- Load-use: ex_is_load=1, ex_wa=7, in_ra2=7, in_uses_ra2=1 → in_ready=0 for that cycle and stall_cnt=1. The next cycle (mem_wa=7, mem_wd=32'hDEAD) fires with out_op2=32'hDEAD. Repeating with in_uses_ra2=0 → no stall.
- Backpressure: out_ready=0 while out_valid=1 → in_ready=0 and outputs hold for 3 cycles. Then out_ready=1 → the next instruction is captured on that edge.
- Flush and zero register: flush=1 with in_valid=1 → out_valid=0 next cycle and nothing captured. ra1=0 with wb_wa=0, wb_wd=32'hFFFF_FFFF → out_op1=0.
